// File: rtl/bg_pixel_drain.sv
// Background pixel FIFO drain: drops SCX fine-scroll pixels, writes X_MAX shades per line to the framebuffer.
// Optional macro DMG_PALETTE_EN maps each colour index through BGP; otherwise the raw index is written.
module bg_pixel_drain #(
    parameter int X_MAX           = 160,
    parameter int Y_MAX           = 144,
    parameter int TOTAL_SCANLINES = 154,
    parameter int FB_ADDR_W       = 15
) (
    input  logic                               clk_in,
    input  logic                               rst_in,
    input  logic                               line_start_in,
    input  logic [$clog2(TOTAL_SCANLINES)-1:0] Y_in,
    input  logic [7:0]                         SCX_in,
    input  logic [7:0]                         BGP_in,
    input  logic                               stall_in,
    output logic                               rd_en,
    input  logic [1:0]                         pixel_in,
    input  logic                               pixel_valid_in,
    output logic [$clog2(X_MAX)-1:0]           X_out,
    output logic [FB_ADDR_W-1:0]               fb_addr_out,
    output logic [1:0]                         fb_data_out,
    output logic                               fb_wr_out,
    output logic                               line_done_out,
    output logic                               restart_err_out
);
    localparam int Y_W = $clog2(TOTAL_SCANLINES);
    localparam int X_W = $clog2(X_MAX);
    localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(Y_MAX);
    localparam logic [X_W-1:0] X_LAST  = X_W'(X_MAX - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DISCARD = 2'd1;
    localparam logic [1:0] S_PUSH    = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]           state_q, state_d;
    logic [2:0]           discard_q, discard_d;
    logic [FB_ADDR_W-1:0] line_base_q, line_base_d;
    logic [X_W-1:0]       x_q, x_d;
    logic                 rd_en_q, rd_en_d;
    logic                 fb_wr_q, fb_wr_d;
    logic [FB_ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [1:0]           fb_data_q, fb_data_d;
    logic                 line_done_q, line_done_d;
    logic                 restart_err_q, restart_err_d;

    logic [1:0]           shade;
    logic [FB_ADDR_W-1:0] line_base_new;
    logic                 start_ok;

    assign line_base_new = FB_ADDR_W'(Y_in) * FB_ADDR_W'(X_MAX);
    assign start_ok      = line_start_in && (Y_in < Y_LIMIT);

`ifdef DMG_PALETTE_EN
    logic unused_scx;
    assign unused_scx = ^SCX_in[7:3];
    assign shade      = BGP_in[{pixel_in, 1'b0} +: 2];
`else
    logic unused_cfg;
    assign unused_cfg = ^{BGP_in, SCX_in[7:3]};
    assign shade      = pixel_in;
`endif

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves it unassigned (no latches).
        state_d       = state_q;
        discard_d     = discard_q;
        line_base_d   = line_base_q;
        x_d           = x_q;
        fb_wr_d       = 1'b0;
        fb_addr_d     = fb_addr_q;
        fb_data_d     = fb_data_q;
        line_done_d   = 1'b0;
        restart_err_d = restart_err_q;

        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_DISCARD: begin
                if (pixel_valid_in) begin
                    discard_d = discard_q - 3'd1;
                    if (discard_q == 3'd1) state_d = S_PUSH;
                end
            end
            S_PUSH: begin
                if (pixel_valid_in) begin
                    fb_wr_d   = 1'b1;
                    fb_addr_d = line_base_q + FB_ADDR_W'(x_q);
                    fb_data_d = shade;
                    if (x_q == X_LAST) begin
                        line_done_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A restart overrides the line state, but a write captured this cycle still goes out.
        if (line_start_in) begin
            if (state_q != S_IDLE) begin
                restart_err_d = 1'b1;
                state_d       = S_IDLE;
            end
            if (start_ok) begin
                discard_d   = SCX_in[2:0];
                line_base_d = line_base_new;
                x_d         = '0;
                state_d     = (SCX_in[2:0] != 3'd0) ? S_DISCARD : S_PUSH;
            end
        end

        // Requests follow the next state, so rd_en falls on the edge that takes the last pixel.
        rd_en_d = ((state_d == S_DISCARD) || (state_d == S_PUSH)) && !stall_in;
    end

    always_ff @(posedge clk_in) begin
        // NOTE: synchronous reset, checked first so it dominates; all state uses non-blocking assignment.
        if (rst_in) begin
            state_q       <= S_IDLE;
            discard_q     <= '0;
            line_base_q   <= '0;
            x_q           <= '0;
            rd_en_q       <= 1'b0;
            fb_wr_q       <= 1'b0;
            fb_addr_q     <= '0;
            fb_data_q     <= '0;
            line_done_q   <= 1'b0;
            restart_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            discard_q     <= discard_d;
            line_base_q   <= line_base_d;
            x_q           <= x_d;
            rd_en_q       <= rd_en_d;
            fb_wr_q       <= fb_wr_d;
            fb_addr_q     <= fb_addr_d;
            fb_data_q     <= fb_data_d;
            line_done_q   <= line_done_d;
            restart_err_q <= restart_err_d;
        end
    end

    assign rd_en           = rd_en_q;
    assign X_out           = x_q;
    assign fb_addr_out     = fb_addr_q;
    assign fb_data_out     = fb_data_q;
    assign fb_wr_out       = fb_wr_q;
    assign line_done_out   = line_done_q;
    assign restart_err_out = restart_err_q;

endmodule

// File: tb/tb_bg_pixel_drain.sv
// Randomised bench for bg_pixel_drain: a FIFO model answers rd_en, a line-level model predicts every
// framebuffer write into a queue, and a monitor pops and compares each write the DUT issues.
module tb_bg_pixel_drain;
    localparam int X_MAX = 160;
    localparam int Y_MAX = 144;
`ifdef DMG_PALETTE_EN
    localparam bit PAL = 1'b1;
`else
    localparam bit PAL = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_in, line_start_in, stall_in, pixel_valid_in;
    logic [7:0]  Y_in, SCX_in, BGP_in;
    logic [1:0]  pixel_in;
    logic        rd_en, fb_wr_out, line_done_out, restart_err_out;
    logic [7:0]  X_out;
    logic [14:0] fb_addr_out;
    logic [1:0]  fb_data_out;

    bg_pixel_drain dut (
        .clk_in(clk_in), .rst_in(rst_in), .line_start_in(line_start_in), .Y_in(Y_in),
        .SCX_in(SCX_in), .BGP_in(BGP_in), .stall_in(stall_in), .rd_en(rd_en),
        .pixel_in(pixel_in), .pixel_valid_in(pixel_valid_in), .X_out(X_out),
        .fb_addr_out(fb_addr_out), .fb_data_out(fb_data_out), .fb_wr_out(fb_wr_out),
        .line_done_out(line_done_out), .restart_err_out(restart_err_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct { int addr; int data; bit last; } exp_t;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;

    // Line-level reference state
    bit   line_active = 1'b0;
    int   drop_left, base, wcount;
    bit   err_exp = 1'b0;
    bit   req_pending = 1'b0;
    logic [1:0] req_pix;
    bit   seq_mode = 1'b0;
    int   seq_cnt = 0;
    bit   bgp_rand = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    function automatic int shade_of(input int idx, input logic [7:0] bgp);
        int mapped;
        mapped = int'((bgp >> (2 * idx)) & 8'd3);
        return PAL ? mapped : idx;
    endfunction

    // A pixel handed over at this negedge is taken by the DUT at the next posedge.
    task automatic model_accept(input logic [1:0] pix);
        exp_t e;
        if (line_active) begin
            if (drop_left > 0) begin
                drop_left--;
            end else begin
                e.addr = base + wcount;
                e.data = shade_of(int'(pix), BGP_in);
                e.last = (wcount == X_MAX - 1);
                exp_q.push_back(e);
                wcount++;
                if (wcount == X_MAX) line_active = 1'b0;
            end
        end
    endtask

    // One clock: FIFO answers a request one cycle after it sees rd_en.
    task automatic tick(input bit start, input bit hold);
        @(negedge clk_in);
        if (bgp_rand) BGP_in = 8'($urandom);
        line_start_in  = start;
        pixel_valid_in = 1'b0;
        if (req_pending && !hold) begin
            pixel_valid_in = 1'b1;
            pixel_in       = req_pix;
            model_accept(req_pix);
            req_pending = 1'b0;
        end
        if (!req_pending && rd_en === 1'b1 && $urandom_range(0, 3) != 0) begin
            req_pending = 1'b1;
            req_pix     = seq_mode ? 2'(seq_cnt % 4) : 2'($urandom_range(0, 3));
            seq_cnt++;
        end
    endtask

    task automatic start_line(input int y, input int scx, input bit expect_err);
        Y_in    = 8'(y);
        SCX_in  = 8'(scx);
        seq_cnt = 0;
        tick(1'b1, 1'b1);
        if (y < Y_MAX) begin
            line_active = 1'b1;
            drop_left   = scx % 8;
            base        = y * X_MAX;
            wcount      = 0;
        end else if (expect_err) begin
            line_active = 1'b0;
        end
        if (expect_err) err_exp = 1'b1;
    endtask

    task automatic run_until_done(input string name, input bit rand_stall);
        int n = 0;
        while ((line_active || exp_q.size() != 0) && n < 4000) begin
            stall_in = rand_stall ? ($urandom_range(0, 5) == 0) : 1'b0;
            tick(1'b0, 1'b0);
            n++;
        end
        stall_in = 1'b0;
        check({name, "_complete"}, 32'(n < 4000), 1);
        repeat (4) tick(1'b0, 1'b0);
        check({name, "_rd_en_idle"}, 32'(rd_en), 0);
        check({name, "_x_final"}, 32'(X_out), X_MAX - 1);
        check({name, "_restart_err"}, 32'(restart_err_out), 32'(err_exp));
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rd_en"}, 32'(rd_en), 0);
        check({name, "_x"}, 32'(X_out), 0);
        check({name, "_addr"}, 32'(fb_addr_out), 0);
        check({name, "_data"}, 32'(fb_data_out), 0);
        check({name, "_wr"}, 32'(fb_wr_out), 0);
        check({name, "_done"}, 32'(line_done_out), 0);
        check({name, "_err"}, 32'(restart_err_out), 0);
    endtask

    // Monitor: every DUT write must match the oldest prediction.
    always @(posedge clk_in) begin
        #1;
        if (fb_wr_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write got addr %0d data %0d want no write", fb_addr_out, fb_data_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(fb_addr_out), e.addr);
                check("wr_data", 32'(fb_data_out), e.data);
                check("wr_line_done", 32'(line_done_out), 32'(e.last));
            end
        end else if (line_done_out === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL line_done_without_write got 1 want 0");
        end
    end

    initial begin
        int n;
        rst_in = 1'b1; line_start_in = 1'b0; stall_in = 1'b0; pixel_valid_in = 1'b0;
        Y_in = '0; SCX_in = '0; BGP_in = 8'hE4; pixel_in = '0;
        repeat (3) tick(1'b0, 1'b1);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        repeat (2) tick(1'b0, 1'b0);

        // Plain line, indices cycle 0..3
        seq_mode = 1'b1;
        start_line(0, 0, 1'b0);
        run_until_done("line_y0", 1'b0);

        // Fine scroll of 5 on line 10
        seq_mode = 1'b0;
        start_line(10, 5, 1'b0);
        run_until_done("line_scx5", 1'b0);

        // Inverting palette
        seq_mode = 1'b1;
        BGP_in   = 8'h1B;
        start_line(20, 0, 1'b0);
        run_until_done("line_bgp1b", 1'b0);
        seq_mode = 1'b0;

        // Long stall mid-line
        start_line(30, 3, 1'b0);
        n = 0;
        while (wcount < 40 && n < 2000) begin tick(1'b0, 1'b0); n++; end
        check("stall_reach_x40", 32'(n < 2000), 1);
        stall_in = 1'b1;
        tick(1'b0, 1'b0);
        check("stall_rd_en_drop", 32'(rd_en), 0);
        for (int i = 0; i < 19; i++) begin
            tick(1'b0, 1'b0);
            check("stall_rd_en_low", 32'(rd_en), 0);
        end
        stall_in = 1'b0;
        run_until_done("line_stall", 1'b0);

        // Restart at X=50
        start_line(40, 2, 1'b0);
        n = 0;
        while (X_out !== 8'd50 && n < 2000) begin tick(1'b0, 1'b0); n++; end
        check("restart_reach_x50", 32'(n < 2000), 1);
        start_line(50, 1, 1'b1);
        tick(1'b0, 1'b0);
        check("restart_err_set", 32'(restart_err_out), 1);
        check("restart_x_cleared", 32'(X_out), 0);
        run_until_done("line_restart", 1'b0);

        // Reset mid-line
        start_line(60, 0, 1'b0);
        repeat (30) tick(1'b0, 1'b0);
        rst_in = 1'b1;
        tick(1'b0, 1'b1);
        exp_q.delete();
        line_active = 1'b0;
        req_pending = 1'b0;
        err_exp     = 1'b0;
        check_reset_outputs("midline_reset");
        rst_in = 1'b0;
        repeat (2) tick(1'b0, 1'b0);

        // Start on a non-visible line is ignored
        start_line(Y_MAX, 3, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick(1'b0, 1'b0);
            check("y144_rd_en", 32'(rd_en), 0);
        end

        // Random lines with random stalls and per-pixel palette changes
        bgp_rand = 1'b1;
        for (int l = 0; l < 8; l++) begin
            start_line(int'($urandom_range(0, Y_MAX - 1)), int'($urandom_range(0, 255)), 1'b0);
            run_until_done("line_rand", 1'b1);
        end
        bgp_rand = 1'b0;

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
